// File: rtl/decoder_stage_riscv.sv
// Buffered RV32I decode stage: decodes fetched instr/pc into the control
// bundle and queues it (DEPTH entries) for execute. Ports: clk_i, rst_ni,
// flush_i, in_valid_i/in_ready_o, instr_i, pc_i, out_valid_o/out_ready_i,
// instr_o, pc_o, head control bundle, occupancy_o.
// Optional: `define DECODER_ZICSR_EN enables Zicsr CSR instructions.
module decoder_stage_riscv #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [31:0]              instr_i,
  input  logic [PC_W-1:0]          pc_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              instr_o,
  output logic [PC_W-1:0]          pc_o,
  output logic [1:0]               a_sel_o,
  output logic [2:0]               b_sel_o,
  output logic [4:0]               alu_op_o,
  output logic [2:0]               csr_op_o,
  output logic                     csr_we_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [2:0]               mem_size_o,
  output logic                     gpr_we_o,
  output logic [1:0]               wb_sel_o,
  output logic                     illegal_instr_o,
  output logic                     branch_o,
  output logic                     jal_o,
  output logic                     jalr_o,
  output logic                     mret_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_XOR  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_AND  = 5'd4;
  localparam logic [4:0] ALU_SRA  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SLL  = 5'd7;
  localparam logic [4:0] ALU_LT   = 5'd8;
  localparam logic [4:0] ALU_LTU  = 5'd9;
  localparam logic [4:0] ALU_GE   = 5'd10;
  localparam logic [4:0] ALU_GEU  = 5'd11;
  localparam logic [4:0] ALU_EQ   = 5'd12;
  localparam logic [4:0] ALU_NE   = 5'd13;
  localparam logic [4:0] ALU_SLTS = 5'd14;
  localparam logic [4:0] ALU_SLTU = 5'd15;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] MRET = 32'h30200073;

  typedef struct packed {
    logic [1:0] a_sel;
    logic [2:0] b_sel;
    logic [4:0] alu_op;
    logic [2:0] csr_op;
    logic       csr_we;
    logic       mem_req;
    logic       mem_we;
    logic [2:0] mem_size;
    logic       gpr_we;
    logic [1:0] wb_sel;
    logic       illegal;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       mret;
  } ctrl_t;

  typedef struct packed {
    ctrl_t             ctrl;
    logic [31:0]       instr;
    logic [PC_W-1:0]   pc;
  } entry_t;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  ctrl_t      dec;
  logic       ill;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];

  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_ADD;
    ill        = 1'b0;
    unique case (1'b1)
      opc == OPC_OP: begin
        dec.gpr_we = 1'b1;
        unique case ({f7, f3})
          10'b0000000_000: dec.alu_op = ALU_ADD;
          10'b0100000_000: dec.alu_op = ALU_SUB;
          10'b0000000_100: dec.alu_op = ALU_XOR;
          10'b0000000_110: dec.alu_op = ALU_OR;
          10'b0000000_111: dec.alu_op = ALU_AND;
          10'b0000000_001: dec.alu_op = ALU_SLL;
          10'b0000000_101: dec.alu_op = ALU_SRL;
          10'b0100000_101: dec.alu_op = ALU_SRA;
          10'b0000000_010: dec.alu_op = ALU_SLTS;
          10'b0000000_011: dec.alu_op = ALU_SLTU;
          default:         ill = 1'b1;
        endcase
      end
      opc == OPC_OP_IMM: begin
        dec.b_sel  = 3'd1;
        dec.gpr_we = 1'b1;
        unique case (f3)
          3'b000: dec.alu_op = ALU_ADD;
          3'b100: dec.alu_op = ALU_XOR;
          3'b110: dec.alu_op = ALU_OR;
          3'b111: dec.alu_op = ALU_AND;
          3'b010: dec.alu_op = ALU_SLTS;
          3'b011: dec.alu_op = ALU_SLTU;
          3'b001: begin
            dec.alu_op = ALU_SLL;
            ill = (f7 != 7'b0000000);
          end
          default: begin
            unique case (f7)
              7'b0000000: dec.alu_op = ALU_SRL;
              7'b0100000: dec.alu_op = ALU_SRA;
              default:    ill = 1'b1;
            endcase
          end
        endcase
      end
      opc == OPC_LOAD: begin
        dec.b_sel    = 3'd1;
        dec.mem_req  = 1'b1;
        dec.gpr_we   = 1'b1;
        dec.wb_sel   = 2'd1;
        dec.mem_size = f3;
        ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      opc == OPC_STORE: begin
        dec.b_sel    = 3'd3;
        dec.mem_req  = 1'b1;
        dec.mem_we   = 1'b1;
        dec.mem_size = f3;
        ill = f3[2] || (f3 == 3'b011);
      end
      opc == OPC_LUI: begin
        dec.a_sel  = 2'd2;
        dec.b_sel  = 3'd2;
        dec.gpr_we = 1'b1;
      end
      opc == OPC_AUIPC: begin
        dec.a_sel  = 2'd1;
        dec.b_sel  = 3'd2;
        dec.gpr_we = 1'b1;
      end
      opc == OPC_BRANCH: begin
        dec.branch = 1'b1;
        unique case (f3)
          3'b000:  dec.alu_op = ALU_EQ;
          3'b001:  dec.alu_op = ALU_NE;
          3'b100:  dec.alu_op = ALU_LT;
          3'b101:  dec.alu_op = ALU_GE;
          3'b110:  dec.alu_op = ALU_LTU;
          3'b111:  dec.alu_op = ALU_GEU;
          default: ill = 1'b1;
        endcase
      end
      opc == OPC_JAL: begin
        dec.a_sel  = 2'd1;
        dec.b_sel  = 3'd4;
        dec.jal    = 1'b1;
        dec.gpr_we = 1'b1;
      end
      opc == OPC_JALR: begin
        dec.a_sel  = 2'd1;
        dec.b_sel  = 3'd4;
        dec.jalr   = 1'b1;
        dec.gpr_we = 1'b1;
        ill = (f3 != 3'b000);
      end
      opc == OPC_MISC: begin
        ill = (f3 != 3'b000);
      end
      opc == OPC_SYSTEM: begin
        if (instr_i == MRET) begin
          dec.mret = 1'b1;
        end else begin
`ifdef DECODER_ZICSR_EN
          if (f3 == 3'b000 || f3 == 3'b100) begin
            ill = 1'b1;
          end else begin
            dec.csr_we = 1'b1;
            dec.csr_op = f3;
            dec.gpr_we = 1'b1;
            dec.wb_sel = 2'd2;
          end
`else
          ill = 1'b1;
`endif
        end
      end
      default: ill = 1'b1;
    endcase
    if (instr_i[1:0] != 2'b11) ill = 1'b1;
    // Illegal entries still flow in order so execute can trap precisely
    if (ill) begin
      dec.illegal = 1'b1;
      dec.gpr_we  = 1'b0;
      dec.mem_req = 1'b0;
      dec.mem_we  = 1'b0;
      dec.csr_we  = 1'b0;
      dec.branch  = 1'b0;
      dec.jal     = 1'b0;
      dec.jalr    = 1'b0;
      dec.mret    = 1'b0;
    end
  end

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  entry_t          head;

  assign in_ready_o  = (count < FULL);
  assign out_valid_o = (count != '0);
  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: reads are masked while empty
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= '{ctrl: dec, instr: instr_i, pc: pc_i};
  end

  assign head = out_valid_o ? mem[rptr] : '0;

  assign occupancy_o     = count;
  assign instr_o         = head.instr;
  assign pc_o            = head.pc;
  assign a_sel_o         = head.ctrl.a_sel;
  assign b_sel_o         = head.ctrl.b_sel;
  assign alu_op_o        = head.ctrl.alu_op;
  assign mem_req_o       = head.ctrl.mem_req;
  assign mem_we_o        = head.ctrl.mem_we;
  assign mem_size_o      = head.ctrl.mem_size;
  assign gpr_we_o        = head.ctrl.gpr_we;
  assign wb_sel_o        = head.ctrl.wb_sel;
  assign illegal_instr_o = head.ctrl.illegal;
  assign branch_o        = head.ctrl.branch;
  assign jal_o           = head.ctrl.jal;
  assign jalr_o          = head.ctrl.jalr;
  assign mret_o          = head.ctrl.mret;

`ifdef DECODER_ZICSR_EN
  assign csr_op_o = head.ctrl.csr_op;
  assign csr_we_o = head.ctrl.csr_we;
`else
  logic unused_csr;
  assign unused_csr = ^{head.ctrl.csr_op, head.ctrl.csr_we};
  assign csr_op_o = 3'b000;
  assign csr_we_o = 1'b0;
`endif

endmodule

// File: doc/decoder_stage_riscv.md
# decoder_stage_riscv

Registered, buffered instruction-decode stage. It sits between instruction fetch and execute in the pipelined core. Each fetched instruction (with its PC) is accepted over a valid/ready handshake and decoded into the core control bundle. The result is held in a parametrised-depth queue until execute consumes it, and a flush discards all queued work.

## Interface
Parameters:
- DEPTH, 2: queue entries; power of two, 2..16.
- PC_W, 32: width of the PC carried with each instruction.

Ports:
- clk_i, input, 1: clock; all state updates on the rising edge.
- rst_ni, input, 1: asynchronous, active-low reset.
- flush_i, input, 1: discard all queued entries and any same-cycle input.
- in_valid_i, input, 1: instruction/PC valid.
- in_ready_o, output, 1: stage can accept.
- instr_i, input, 32: fetched instruction.
- pc_i, input, PC_W: instruction address.
- out_valid_o, output, 1: head entry valid.
- out_ready_i, input, 1: execute consumes head.
- instr_o, output, 32: head instruction.
- pc_o, output, PC_W: head PC.
- Control bundle of the head entry, using riscv_pkg encodings:
  - a_sel_o [1:0]
  - b_sel_o [2:0]
  - alu_op_o [4:0]
  - csr_op_o [2:0]
  - csr_we_o
  - mem_req_o
  - mem_we_o
  - mem_size_o [2:0]
  - gpr_we_o
  - wb_sel_o [1:0]
  - illegal_instr_o
  - branch_o
  - jal_o
  - jalr_o
  - mret_o
- occupancy_o, output, $clog2(DEPTH)+1: current entry count.

## Operation
- Decode is combinational on instr_i. Only the decoded bundle, instr and pc are written into the queue.
- Default bundle:
  - a_sel=0 (rs1), b_sel=0 (rs2), alu_op=ALU_ADD, wb_sel=0 (ALU), mem_size=0, csr_op=0.
  - All enables and flags 0.
- Decode rules (instr[1:0]!=2'b11 or an unlisted opcode: illegal):
  - OP: gpr_we=1. ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLTS, SLTU selected by exact funct3/funct7 pairs; any other pair is illegal.
  - OP_IMM: b_sel=1 (imm_I), gpr_we=1.
    - ADDI, XORI, ORI, ANDI, SLTI, SLTIU: decoded on funct3 alone.
    - SLLI/SRLI: require funct7=0000000.
    - SRAI: requires funct7=0100000.
  - LOAD: b_sel=1, mem_req=1, gpr_we=1, wb_sel=1, mem_size=funct3. funct3 must be in {000,001,010,100,101}.
  - STORE: b_sel=3 (imm_S), mem_req=1, mem_we=1, mem_size=funct3. funct3 must be in {000,001,010}.
  - LUI: a_sel=2 (zero), b_sel=2 (imm_U), gpr_we=1.
  - AUIPC: a_sel=1 (PC), b_sel=2, gpr_we=1.
  - BRANCH: branch=1. alu_op is the compare op for funct3; funct3 010/011 are illegal.
  - JAL: a_sel=1, b_sel=4 (const 4), jal=1, gpr_we=1.
  - JALR: same selects as JAL, jalr=1, gpr_we=1; funct3 must be 000.
  - MISC_MEM: funct3=000 decodes to the default bundle (no-op).
  - SYSTEM: instr==32'h30200073 gives mret=1. CSR rules are under Configuration. Anything else is illegal.
- Any illegal instruction:
  - illegal_instr=1.
  - gpr_we, mem_req, mem_we, csr_we, branch, jal, jalr, mret are forced 0.
  - The entry is still queued in order.
- Queue:
  - Circular buffer with read/write pointers that wrap modulo DEPTH, plus a count.
  - push = in_valid_i & in_ready_o & !flush_i.
  - pop = out_valid_o & out_ready_i & !flush_i.
  - Push and pop in the same cycle leave the count unchanged.
- Flush: pointers and count go to 0 on the next edge. Flush overrides push and pop in that cycle.

## Timing
- Reset values:
  - out_valid_o=0, occupancy_o=0, in_ready_o=1.
  - All bundle outputs and instr_o/pc_o are 0.
- Latency: an instruction accepted at edge N is visible at out_valid_o after edge N (one cycle).
- in_ready_o = (count<DEPTH). It does not depend on out_ready_i, so there is no combinational ready path.
  - When full, a pop frees space only from the next cycle.
- Head outputs are stable while out_valid_o=1 and out_ready_i=0.
- Outputs are taken from the head entry. They are zero whenever the queue is empty.
- Asserting rst_ni low mid-operation empties the queue immediately.
- Throughput: one instruction per cycle whenever not full.

## Configuration
- DECODER_ZICSR_EN defined:
  - SYSTEM with funct3 in {001,010,011,101,110,111} gives csr_we=1, csr_op=funct3, gpr_we=1, wb_sel=2 (CSR).
  - SYSTEM with funct3=100 is illegal.
- DECODER_ZICSR_EN undefined:
  - Every SYSTEM encoding except mret is illegal.
  - csr_we_o and csr_op_o are tied 0.

## Test plan
- Push 32'h00B50533 (add) at pc 0x100, out_ready=1 -> next cycle: out_valid=1, alu_op=ALU_ADD, gpr_we=1, pc_o=0x100; then 32'h40B50533 (sub) -> alu_op=ALU_SUB.
- Push 32'h00000000 and 32'h0000007F -> both illegal_instr=1 with all enables 0, delivered in order.
- DEPTH=2, out_ready=0, push 3 instructions -> in_ready=0 after the second, occupancy=2; raise out_ready -> pops in order, in_ready returns high the cycle after the first pop.
- Fill 2 entries, assert flush_i together with in_valid -> next cycle occupancy=0, out_valid=0, the input is dropped.
- Push 32'h34011073 (csrrw): with DECODER_ZICSR_EN -> csr_we=1, csr_op=3'b001, wb_sel=2; without it -> illegal=1. Push 32'h30200073 -> mret=1 in both builds.
- Pull rst_ni low with 2 entries queued mid-stream -> out_valid=0 and occupancy=0 immediately, in_ready=1.
